// File: rtl/halt_dump_ctrl_pkg.sv
// Shared definitions for halt_dump_ctrl: FSM states, halt encoding,
// default sizing, and the dump payload layout.
package halt_dump_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned CNT_W  = 32;

    localparam int unsigned DEPTH_DEF        = 512;
    localparam int unsigned DRAIN_CYCLES_DEF = 4;
    localparam int unsigned MAX_CYCLES_DEF   = 100000;

    localparam logic [DATA_W-1:0] HALT_WORD_DEF = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_READ,
        ST_PRESENT,
        ST_DONE
    } state_t;

    // One dumped RAM word together with its address.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  index;
    } dump_word_t;

endpackage

// File: rtl/halt_dump_ctrl.sv
// halt_dump_ctrl: runs until the CPU decodes the halt word (or a cycle
// timeout), drains the pipeline, freezes the CPU, then streams the whole
// data RAM out over a valid/ready port in ascending address order.
//
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   instr_d                decode-stage instruction (watched only in RUN)
//   cpu_freeze             holds the CPU once the drain has completed
//   mem_addr / mem_rdata   data-RAM read port (data valid one cycle later)
//   dump_valid/ready/data/index  dump stream with handshake
//   cycle_count            clocks spent in RUN and DRAIN (saturating)
//   timeout, done          sticky status flags
module halt_dump_ctrl
    import halt_dump_ctrl_pkg::*;
#(
    parameter int unsigned       DEPTH        = DEPTH_DEF,
    parameter int unsigned       DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned       MAX_CYCLES   = MAX_CYCLES_DEF,
    parameter logic [DATA_W-1:0] HALT_WORD    = HALT_WORD_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] instr_d,
    output logic              cpu_freeze,
    output logic [IDX_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [IDX_W-1:0]  dump_index,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              timeout,
    output logic              done
);

    // DEPTH must not exceed 2**IDX_W; the index counter is IDX_W bits.
    localparam int unsigned       DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MAX_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DEPTH - 1);

    state_t           r_state,       w_state_nxt;
    logic [CNT_W-1:0] r_cycle_count, w_cycle_count_nxt;
    logic [DRN_W-1:0] r_drain_cnt,   w_drain_cnt_nxt;
    logic [IDX_W-1:0] r_index,       w_index_nxt;
    logic [IDX_W-1:0] r_mem_addr,    w_mem_addr_nxt;
    dump_word_t       r_dump,        w_dump_nxt;
    logic             r_dump_valid,  w_dump_valid_nxt;
    logic             r_cpu_freeze,  w_cpu_freeze_nxt;
    logic             r_timeout,     w_timeout_nxt;
    logic             r_done,        w_done_nxt;
    logic [CNT_W-1:0] w_cycle_inc;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RUN;
            r_cycle_count <= '0;
            r_drain_cnt   <= '0;
            r_index       <= '0;
            r_mem_addr    <= '0;
            r_dump        <= '0;
            r_dump_valid  <= 1'b0;
            r_cpu_freeze  <= 1'b0;
            r_timeout     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cycle_count <= w_cycle_count_nxt;
            r_drain_cnt   <= w_drain_cnt_nxt;
            r_index       <= w_index_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_dump        <= w_dump_nxt;
            r_dump_valid  <= w_dump_valid_nxt;
            r_cpu_freeze  <= w_cpu_freeze_nxt;
            r_timeout     <= w_timeout_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_cycle_count_nxt = r_cycle_count;
        w_drain_cnt_nxt   = r_drain_cnt;
        w_index_nxt       = r_index;
        w_mem_addr_nxt    = r_mem_addr;
        w_dump_nxt        = r_dump;
        w_dump_valid_nxt  = r_dump_valid;
        w_cpu_freeze_nxt  = r_cpu_freeze;
        w_timeout_nxt     = r_timeout;
        w_done_nxt        = r_done;

        // Saturating increment, used only while running or draining.
        w_cycle_inc = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + CNT_W'(1);

        unique case (r_state)
            ST_RUN: begin
                w_cycle_count_nxt = w_cycle_inc;
                // Halt word has priority over a coincident timeout.
                if (instr_d == HALT_WORD) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = '0;
                end else if (r_cycle_count == MAX_LAST) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = '0;
                    w_timeout_nxt   = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_cycle_count_nxt = w_cycle_inc;
                if (r_drain_cnt == DRN_LAST) begin
                    w_state_nxt      = ST_READ;
                    w_cpu_freeze_nxt = 1'b1;
                    w_mem_addr_nxt   = r_index;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + DRN_W'(1);
                end
            end
            ST_READ: begin
                // RAM data for r_mem_addr is valid on this edge.
                w_state_nxt      = ST_PRESENT;
                w_dump_nxt.data  = mem_rdata;
                w_dump_nxt.index = r_mem_addr;
                w_dump_valid_nxt = 1'b1;
            end
            ST_PRESENT: begin
                if (r_dump_valid && dump_ready) begin
                    w_dump_valid_nxt = 1'b0;
                    if (r_dump.index == IDX_LAST) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt    = ST_READ;
                        w_index_nxt    = r_index + IDX_W'(1);
                        w_mem_addr_nxt = r_index + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_dump_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign cpu_freeze  = r_cpu_freeze;
    assign mem_addr    = r_mem_addr;
    assign dump_valid  = r_dump_valid;
    assign dump_data   = r_dump.data;
    assign dump_index  = r_dump.index;
    assign cycle_count = r_cycle_count;
    assign timeout     = r_timeout;
    assign done        = r_done;

endmodule
